// File: rtl/lwe_pkg.sv
// ============================================================================
// Module  : lwe_pkg
// Purpose : Shared definitions for the LWE encrypt datapath: plaintext
//           scaling factor, counter widths and FSM state encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lwe_pkg;

    // Scaling factor that lifts a plaintext symbol into the ciphertext ring.
    function automatic int calc_delta(input int q, input int p);
        return q / p;
    endfunction

    // Width of a column counter that must reach DIMENSION inclusive.
    function automatic int calc_col_w(input int dimension);
        return (dimension > 0) ? $clog2(dimension + 1) : 1;
    endfunction

    // Width of a row counter that must reach BIG_N-1.
    function automatic int calc_row_w(input int big_n);
        return (big_n > 1) ? $clog2(big_n) : 1;
    endfunction

    // Values for the default parameter set.
    localparam int DELTA = calc_delta(1024, 64);
    localparam int COL_W = calc_col_w(10);
    localparam int ROW_W = calc_row_w(30);

    // FSM state encoding.
    localparam int          STATE_W   = 2;
    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_ACCUM  = 2'd1;
    localparam logic [1:0]  ST_OUTPUT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/encrypt_if.sv
// ============================================================================
// Module  : encrypt_if
// Purpose : Streaming bus of the encrypt engine: public-key input stream
//           with per-row selection bit, and ciphertext output stream.
// Signals : pk_valid/pk_ready/pk_entry/rand_bit  - public-key stream
//           ct_valid/ct_ready/ct_entry/ct_index/ct_last - ciphertext stream
// Modports: master - system side (drives key stream, sinks ciphertext)
//           slave  - encrypt engine
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface encrypt_if #(
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int DIMENSION        = 10
);
    import lwe_pkg::*;

    logic                        pk_valid;
    logic                        pk_ready;
    logic [CIPHERTEXT_WIDTH-1:0] pk_entry;
    logic                        rand_bit;

    logic                        ct_valid;
    logic                        ct_ready;
    logic [CIPHERTEXT_WIDTH-1:0] ct_entry;
    logic [DIMENSION:0]          ct_index;
    logic                        ct_last;

    modport master (
        output pk_valid, pk_entry, rand_bit, ct_ready,
        input  pk_ready, ct_valid, ct_entry, ct_index, ct_last
    );

    modport slave (
        input  pk_valid, pk_entry, rand_bit, ct_ready,
        output pk_ready, ct_valid, ct_entry, ct_index, ct_last
    );

endinterface

`default_nettype wire

// File: rtl/encrypt_acc_bank.sv
// ============================================================================
// Module  : encrypt_acc_bank
// Purpose : DEPTH accumulator registers. init loads init_val into entry 0
//           and clears the rest; add_en adds add_val (mod 2^WIDTH) into the
//           entry at add_idx; rd_idx selects the entry driven on rd_data.
// Ports   : clk, rst_n (sync active-low), init, init_val, add_en, add_idx,
//           add_val, rd_idx, rd_data
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module encrypt_acc_bank #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 11,
    parameter int IDX_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             init,
    input  wire logic [WIDTH-1:0] init_val,
    input  wire logic             add_en,
    input  wire logic [IDX_W-1:0] add_idx,
    input  wire logic [WIDTH-1:0] add_val,
    input  wire logic [IDX_W-1:0] rd_idx,
    output logic      [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_acc [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_acc[i] <= '0;
            end
        end else if (init) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == 0) begin
                    r_acc[i] <= init_val;
                end else begin
                    r_acc[i] <= '0;
                end
            end
        end else if (add_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (add_idx == IDX_W'(i)) begin
                    // Truncating add gives the mod-2^WIDTH reduction for free.
                    r_acc[i] <= r_acc[i] + add_val;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = r_acc[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/encrypt.sv
// ============================================================================
// Module  : encrypt
// Purpose : Regev/LWE encryption engine. Streams a BIG_N x (DIMENSION+1)
//           public key row-major, sums the rows whose selection bit is set
//           mod q, adds m*DELTA to column 0, then streams the DIMENSION+1
//           ciphertext entries out with a valid/ready handshake.
// Ports   : clk, rst_n (sync active-low), start, plaintext, busy, done,
//           bus (encrypt_if.slave: pk_* key stream, ct_* ciphertext stream)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module encrypt
    import lwe_pkg::*;
#(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 10,
    parameter int DIMENSION          = 10,
    parameter int BIG_N              = 30
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       start,
    input  wire logic [PLAINTEXT_WIDTH-1:0] plaintext,
    output logic                            busy,
    output logic                            done,
    encrypt_if.slave                        bus
);

    localparam int COL_W_P = calc_col_w(DIMENSION);
    localparam int ROW_W_P = calc_row_w(BIG_N);
    localparam int PAD_W   = DIMENSION + 1 - COL_W_P;
    localparam logic [CIPHERTEXT_WIDTH-1:0] C_DELTA =
        CIPHERTEXT_WIDTH'(calc_delta(CIPHERTEXT_MODULUS, PLAINTEXT_MODULUS));
    localparam logic [COL_W_P-1:0] C_COL_LAST = COL_W_P'(DIMENSION);
    localparam logic [ROW_W_P-1:0] C_ROW_LAST = ROW_W_P'(BIG_N - 1);

    logic [STATE_W-1:0]          r_state;
    logic [ROW_W_P-1:0]          r_row;
    logic [COL_W_P-1:0]          r_col;
    logic                        r_rsel;
    logic [COL_W_P-1:0]          r_ct_idx;
    logic                        r_done;

    logic                        w_start_go;
    logic                        w_pk_fire;
    logic                        w_eff_bit;
    logic                        w_col_last;
    logic                        w_row_last;
    logic                        w_ct_fire;
    logic                        w_ct_last;
    logic [CIPHERTEXT_WIDTH-1:0] w_scaled;
    logic [CIPHERTEXT_WIDTH-1:0] w_rd_data;

    assign w_start_go = (r_state == ST_IDLE) && start;
    assign w_pk_fire  = (r_state == ST_ACCUM) && bus.pk_valid;
    // The column-0 beat carries the live selection bit; later beats of the
    // same row reuse the latched copy so mid-row toggles are ignored.
    assign w_eff_bit  = (r_col == '0) ? bus.rand_bit : r_rsel;
    assign w_col_last = (r_col == C_COL_LAST);
    assign w_row_last = (r_row == C_ROW_LAST);
    assign w_ct_fire  = (r_state == ST_OUTPUT) && bus.ct_ready;
    assign w_ct_last  = (r_state == ST_OUTPUT) && (r_ct_idx == C_COL_LAST);
    assign w_scaled   = CIPHERTEXT_WIDTH'(plaintext) * C_DELTA;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_row    <= '0;
            r_col    <= '0;
            r_rsel   <= 1'b0;
            r_ct_idx <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_row    <= '0;
                        r_col    <= '0;
                        r_rsel   <= 1'b0;
                        r_ct_idx <= '0;
                        r_state  <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (bus.pk_valid) begin
                        if (r_col == '0) begin
                            r_rsel <= bus.rand_bit;
                        end
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_state <= ST_OUTPUT;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (bus.ct_ready) begin
                        if (w_ct_last) begin
                            r_ct_idx <= '0;
                            r_done   <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_ct_idx <= r_ct_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    encrypt_acc_bank #(
        .WIDTH (CIPHERTEXT_WIDTH),
        .DEPTH (DIMENSION + 1),
        .IDX_W (COL_W_P)
    ) u_acc_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (w_start_go),
        .init_val (w_scaled),
        .add_en   (w_pk_fire && w_eff_bit),
        .add_idx  (r_col),
        .add_val  (bus.pk_entry),
        .rd_idx   (r_ct_idx),
        .rd_data  (w_rd_data)
    );

    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign bus.pk_ready = (r_state == ST_ACCUM);
    assign bus.ct_valid = (r_state == ST_OUTPUT);
    assign bus.ct_entry = (r_state == ST_OUTPUT) ? w_rd_data : '0;
    assign bus.ct_index = {{PAD_W{1'b0}}, r_ct_idx};
    assign bus.ct_last  = w_ct_last;

    // Handshake fires only in OUTPUT; kept for readability of the FSM above.
    logic w_unused;
    assign w_unused = w_ct_fire;

endmodule

`default_nettype wire

// File: tb/tb_encrypt.sv
// ============================================================================
// Module  : tb_encrypt
// Purpose : Self-checking bench for encrypt. Directed key streams with
//           hand-computed ciphertexts queued per run; an output monitor pops
//           and compares on every ciphertext handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_encrypt;

    localparam int PW   = 6;
    localparam int CW   = 10;
    localparam int DIM  = 10;
    localparam int NR   = 30;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] plaintext = '0;
    logic          busy;
    logic          done;

    encrypt_if #(.CIPHERTEXT_WIDTH(CW), .DIMENSION(DIM)) bus ();

    encrypt #(
        .PLAINTEXT_MODULUS  (64),
        .PLAINTEXT_WIDTH    (PW),
        .CIPHERTEXT_MODULUS (1024),
        .CIPHERTEXT_WIDTH   (CW),
        .DIMENSION          (DIM),
        .BIG_N              (NR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .plaintext (plaintext),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] entry;
        logic [DIM:0]  idx;
        logic          last;
    } ct_t;

    ct_t exp_q[$];
    ct_t mon_t;
    int  tests    = 0;
    int  fails    = 0;
    int  done_cnt = 0;
    bit  bp       = 1'b0;
    int  hold_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ct(input logic [CW-1:0] c0, input logic [CW-1:0] crest);
        ct_t t;
        for (int j = 0; j <= DIM; j++) begin
            t.entry = (j == 0) ? c0 : crest;
            t.idx   = (DIM+1)'(j);
            t.last  = (j == DIM);
            exp_q.push_back(t);
        end
    endtask

    task automatic check_reset();
        check("rst_busy",     {31'd0, busy},         0);
        check("rst_pk_ready", {31'd0, bus.pk_ready}, 0);
        check("rst_ct_valid", {31'd0, bus.ct_valid}, 0);
        check("rst_ct_last",  {31'd0, bus.ct_last},  0);
        check("rst_done",     {31'd0, done},         0);
        check("rst_ct_entry", 32'(bus.ct_entry),     0);
        check("rst_ct_index", 32'(bus.ct_index),     0);
    endtask

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (bus.ct_valid && bus.ct_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ct: got index %0d entry %0d, expected no output",
                         bus.ct_index, bus.ct_entry);
            end else begin
                mon_t = exp_q.pop_front();
                check("ct_entry", 32'(bus.ct_entry), 32'(mon_t.entry));
                check("ct_index", 32'(bus.ct_index), 32'(mon_t.idx));
                check("ct_last",  {31'd0, bus.ct_last}, {31'd0, mon_t.last});
            end
        end else if (bus.ct_valid && !bus.ct_ready && exp_q.size() != 0) begin
            // Stalled beat must keep presenting the pending expected entry.
            check("hold_entry", 32'(bus.ct_entry), 32'(exp_q[0].entry));
            check("hold_index", 32'(bus.ct_index), 32'(exp_q[0].idx));
        end
        if (done) done_cnt++;
    end

    // Ciphertext sink: always ready, or three stall cycles per entry.
    initial begin
        bus.ct_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!bp) begin
                bus.ct_ready = 1'b1;
                hold_cnt     = 0;
            end else if (bus.ct_valid) begin
                if (hold_cnt == 3) begin
                    bus.ct_ready = 1'b1;
                    hold_cnt     = 0;
                end else begin
                    bus.ct_ready = 1'b0;
                    hold_cnt++;
                end
            end else begin
                bus.ct_ready = 1'b0;
                hold_cnt     = 0;
            end
        end
    end

    // kind 0: rand_bit=0, varied entries; 1: all ones; 2: all 1023;
    // 3: entry 1, rows selected when even, rand_bit inverted after col 0,
    //    plus a start pulse with a different plaintext mid-run.
    task automatic run_case(input logic [PW-1:0] m, input int kind,
                            input bit stall, input int abort_row);
        int            guard;
        int            d0;
        bit            aborted;
        logic [CW-1:0] e;
        logic          rb;
        aborted = 1'b0;
        d0      = done_cnt;
        plaintext = m;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        plaintext = ~m;
        check("busy_after_start", {31'd0, busy}, 1);
        for (int row = 0; row < NR; row++) begin
            for (int col = 0; col <= DIM; col++) begin
                if (row == abort_row && col == 0) begin
                    rst_n        = 1'b0;
                    bus.pk_valid = 1'b0;
                    repeat (2) @(posedge clk);
                    #1;
                    check_reset();
                    rst_n   = 1'b1;
                    aborted = 1'b1;
                    break;
                end
                case (kind)
                    0:       begin e = CW'((row * 7 + col * 3) % 1024); rb = 1'b0; end
                    1:       begin e = CW'(1);    rb = 1'b1; end
                    2:       begin e = CW'(1023); rb = 1'b1; end
                    default: begin
                        e  = CW'(1);
                        rb = (col == 0) ? (row % 2 == 0) : (row % 2 == 1);
                    end
                endcase
                if (stall && ((row * (DIM + 1) + col) % 2 == 1)) begin
                    bus.pk_valid = 1'b0;
                    bus.pk_entry = CW'(10'h2AA);
                    bus.rand_bit = ~rb;
                    @(posedge clk);
                    #1;
                end
                guard = 0;
                while (!bus.pk_ready && guard < 50) begin
                    @(posedge clk);
                    #1;
                    guard++;
                end
                if (!bus.pk_ready) begin
                    tests++;
                    fails++;
                    $display("FAIL pk_ready_timeout: got 0, expected 1 at row %0d col %0d", row, col);
                end
                bus.pk_valid = 1'b1;
                bus.pk_entry = e;
                bus.rand_bit = rb;
                if (kind == 3 && row == 5 && col == 3) begin
                    start     = 1'b1;
                    plaintext = PW'(9);
                end
                @(posedge clk);
                #1;
                bus.pk_valid = 1'b0;
                start        = 1'b0;
            end
            if (aborted) break;
        end
        if (!aborted) begin
            check("pk_ready_after_last", {31'd0, bus.pk_ready}, 0);
            check("ct_valid_latency",    {31'd0, bus.ct_valid}, 1);
            guard = 0;
            while (done_cnt == d0 && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            check("done_count", 32'(done_cnt - d0), 1);
            @(negedge clk);
            check("done_one_cycle", {31'd0, done}, 0);
            check("queue_drained",  32'(exp_q.size()), 0);
            check("busy_idle",      {31'd0, busy}, 0);
        end
    endtask

    initial begin
        bus.pk_valid = 1'b0;
        bus.pk_entry = '0;
        bus.rand_bit = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        push_ct(CW'(80), CW'(0));      // m=5, nothing selected
        run_case(PW'(5), 0, 1'b0, -1);

        push_ct(CW'(30), CW'(30));     // m=0, all rows of ones
        run_case(PW'(0), 1, 1'b0, -1);

        push_ct(CW'(978), CW'(994));   // m=63, all rows of 1023 (wraps)
        run_case(PW'(63), 2, 1'b0, -1);

        bp = 1'b1;                     // same vectors under backpressure
        push_ct(CW'(978), CW'(994));
        run_case(PW'(63), 2, 1'b1, -1);
        bp = 1'b0;
        @(posedge clk);
        #1;

        run_case(PW'(7), 1, 1'b0, 12); // aborted by reset at row 12
        push_ct(CW'(16), CW'(0));
        run_case(PW'(1), 0, 1'b0, -1);

        push_ct(CW'(47), CW'(15));     // m=2, 15 even rows of ones
        run_case(PW'(2), 3, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/encrypt.md
Name: encrypt

Overview:
- Regev/LWE public-key encryption engine; the transmit-side counterpart of the team's decrypt block.
- Streams a BIG_N x (DIMENSION+1) public-key matrix in row-major order, with one random selection bit per public-key row.
- Accumulates the selected rows mod CIPHERTEXT_MODULUS and adds the scaled plaintext to column 0.
- Streams the resulting DIMENSION+1 ciphertext entries out with a valid/ready handshake. The entry index is formatted to drive decrypt's row input directly.

Parameters:
- PLAINTEXT_MODULUS, 64, plaintext modulus p; power of two.
- PLAINTEXT_WIDTH, 6, log2(p).
- CIPHERTEXT_MODULUS, 1024, ciphertext modulus q; power of two, greater than p.
- CIPHERTEXT_WIDTH, 10, log2(q).
- DIMENSION, 10, LWE dimension n; ciphertext has n+1 entries.
- BIG_N, 30, number of public-key samples (rows).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin encryption; honoured only in IDLE
- plaintext  in  PLAINTEXT_WIDTH  message m, sampled on the accepted start
- busy  out  1  high in any state other than IDLE
- pk_valid  in  1  public-key entry valid
- pk_ready  out  1  high only in ACCUM
- pk_entry  in  CIPHERTEXT_WIDTH  public-key entry pk[i][j]
- rand_bit  in  1  selection bit r_i; sampled on the column-0 beat of each row
- ct_valid  out  1  ciphertext entry valid
- ct_ready  in  1  downstream accepts entry
- ct_entry  out  CIPHERTEXT_WIDTH  ciphertext entry c[j]
- ct_index  out  DIMENSION+1  j, 0..DIMENSION
- ct_last  out  1  high with ct_valid when j==DIMENSION
- done  out  1  one-cycle pulse after the last ciphertext handshake

Behaviour:
- Reset (rst_n low at posedge):
  - state=IDLE.
  - All accumulators, row/col counters, latched r, ct_index cleared.
  - busy, pk_ready, ct_valid, ct_last, done all 0; ct_entry 0.
  - Reset wins over every other event; a reset mid-ACCUM or mid-OUTPUT abandons the operation with no output.
- Arithmetic:
  - DELTA = q/p (16 by default).
  - All sums are mod q by truncation to CIPHERTEXT_WIDTH bits; entries are unsigned.
- IDLE:
  - start=1 at posedge sets acc[0]=m*DELTA (truncated) and acc[1..n]=0.
  - Clears row/col counters; next state ACCUM.
  - done=0 in all cycles except the pulse cycle.
- ACCUM:
  - pk_ready=1. A beat is accepted when pk_valid&&pk_ready.
  - On the col==0 beat: effective bit = rand_bit, latched for the rest of the row. On later beats: effective bit = the latched value.
  - If the effective bit is 1: acc[col] += pk_entry. If 0: accumulator unchanged.
  - col increments per accepted beat; at col==DIMENSION it wraps to 0 and row increments.
  - The accepted beat with row==BIG_N-1, col==DIMENSION moves to OUTPUT; pk_ready drops the next cycle.
  - Cycles with pk_valid low are stalls with no state change.
- OUTPUT:
  - ct_valid=1; ct_entry=acc[ct_index]; ct_last=(ct_index==DIMENSION).
  - ct_entry and ct_index stay stable while ct_ready=0.
  - Each handshake increments ct_index.
  - The handshake with ct_last moves to IDLE, sets done=1 for exactly one cycle, and resets ct_index to 0.
- Latency: first ct_valid is one cycle after the final pk beat. Minimum total is BIG_N*(n+1)+n+2 cycles from start to done.
- start while busy is ignored (no restart, no effect on the latched plaintext).
- start coincident with the done cycle: done occurs in IDLE, so that start is accepted.
- The ciphertext is ready for direct application to decrypt: ct_entry goes to ciphertext_entry and ct_index to row.

Decomposition:
- Shared package (lwe_pkg):
  - DELTA derivation.
  - Width localparams: COL_W=$clog2(DIMENSION+1), ROW_W=$clog2(BIG_N).
  - State encoding (IDLE/ACCUM/OUTPUT).
- One natural sub-module: encrypt_acc_bank.
  - DIMENSION+1 accumulator registers with init (load m*DELTA into entry 0, clear the rest), conditional add at an index, and read at an index.
- The FSM and counters stay in encrypt.

Test Plan:
- All rand_bit=0, m=5, defaults: ct = {80,0,...,0}; ct_last only on index 10; done pulses once.
- All rand_bit=1, all pk_entry=1, m=0: every c[j]=30.
- Wrap-around: all rand_bit=1, pk_entry=1023, m=63: c[0]=978, c[1..10]=994.
- Backpressure: pk_valid toggled 50% and ct_ready low for 3 cycles per entry: same results as the unstalled run; ct_entry/ct_index held while ct_ready=0.
- rst_n low at row 12 of ACCUM, then a fresh start with m=1 and all r=0: ct={16,0,...}; nothing from the aborted run leaks.
- start pulsed during ACCUM with a different m: ignored, result uses the original m; rand_bit changed mid-row: has no effect on that row.
